// File: rtl/note_sequencer_if.sv
// Signal bundle between the UART byte source / player control and the note sequencer.
interface note_sequencer_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          play_en;
  logic [7:0]    tone;
  logic          tone_en;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  modport master (
    output rx_valid, rx_data, play_en,
    input  tone, tone_en, busy, fifo_count, overflow
  );

  modport slave (
    input  rx_valid, rx_data, play_en,
    output tone, tone_en, busy, fifo_count, overflow
  );
endinterface

// File: rtl/note_sequencer.sv
// Assembles (note, duration) byte pairs from a UART stream into a FIFO and plays
// them on a beeper with millisecond timing and a fixed silent gap after each note.
//
// state | meaning
// IDLE  | waiting for a queued pair and play_en
// LOAD  | one cycle: latch tone, compute remaining ms from duration
// PLAY  | note sounding (gated by play_en), counting down ms
// GAP   | silent gap of GAP_MS after the note
module note_sequencer #(
  parameter int CLK_FREQ = 12000000,
  parameter int DEPTH    = 16,
  parameter int GAP_MS   = 10
) (
  input logic             sys_clk,
  input logic             sys_rst_n,
  note_sequencer_if.slave bus
);
  localparam int MS_DIV = CLK_FREQ / 1000;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int PW     = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int RS_CYC = 255 * MS_DIV;
  localparam int RW     = $clog2(RS_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  state_t        state, state_nx;
  logic          phase;
  logic [7:0]    note_hold;
  logic [RW-1:0] rs_cnt;
  logic          wr_req, wr_ok, full, pop;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx;
  logic          overflow_q;
  logic [7:0]    cur_note, cur_dur;
  logic [11:0]   remain;
  logic [PW-1:0] psc;
  logic          run, tick;
  logic [7:0]    tone_q, tone_nx;
  logic          tone_en_q, tone_en_nx;
  logic          busy_q, busy_nx;

  assign wr_req = bus.rx_valid && phase;

  // A half-received pair is abandoned after 255 ms of silence on the byte stream.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      phase     <= 1'b0;
      note_hold <= '0;
      rs_cnt    <= '0;
    end else if (bus.rx_valid) begin
      phase <= ~phase;
      if (!phase) begin
        note_hold <= bus.rx_data;
        rs_cnt    <= RW'(RS_CYC - 1);
      end
    end else if (phase) begin
      if (rs_cnt == '0) phase <= 1'b0;
      else              rs_cnt <= rs_cnt - RW'(1);
    end
  end

  assign full     = (count == CW'(DEPTH));
  assign wr_ok    = wr_req && !full;
  assign count_nx = count + CW'(wr_ok) - CW'(pop);

  always_ff @(posedge sys_clk) begin
    if (wr_ok) mem[wr_ptr] <= {note_hold, bus.rx_data};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count      <= count_nx;
      overflow_q <= wr_req && full;
    end
  end

  assign run  = bus.play_en && (state == S_PLAY || state == S_GAP);
  assign tick = run && (psc == PW'(MS_DIV - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (count != '0 && bus.play_en) state_nx = S_LOAD;
      S_LOAD:  state_nx = (cur_dur == 8'd0) ? S_IDLE : S_PLAY;
      S_PLAY:  if (tick && remain == 12'd1) state_nx = S_GAP;
      S_GAP:   if (tick && remain == 12'd1) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Sound gate is registered from the next state so it tracks PLAY cycle for cycle.
  always_comb begin
    pop        = (state == S_IDLE) && (state_nx == S_LOAD);
    tone_nx    = (state == S_LOAD) ? cur_note : tone_q;
    tone_en_nx = (state_nx == S_PLAY) && bus.play_en && (tone_nx != 8'd0);
  end

  assign busy_nx = (state_nx != S_IDLE) || (count_nx != '0);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cur_note  <= '0;
      cur_dur   <= '0;
      tone_q    <= '0;
      tone_en_q <= 1'b0;
      busy_q    <= 1'b0;
      remain    <= '0;
      psc       <= '0;
    end else begin
      if (pop) {cur_note, cur_dur} <= mem[rd_ptr];
      tone_q    <= tone_nx;
      tone_en_q <= tone_en_nx;
      busy_q    <= busy_nx;
      if (state == S_LOAD)                           remain <= 12'(cur_dur) * 12'd10;
      else if (state == S_PLAY && state_nx == S_GAP) remain <= 12'(GAP_MS);
      else if (tick)                                 remain <= remain - 12'd1;
      if (state_nx != state) psc <= '0;
      else if (run)          psc <= tick ? '0 : psc + PW'(1);
    end
  end

  assign bus.tone       = tone_q;
  assign bus.tone_en    = tone_en_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Directed and randomized checks of the note sequencer against a queue-based player model.
module tb_note_sequencer;
  localparam int CLK_FREQ = 12000;
  localparam int DEPTH    = 16;
  localparam int GAP_MS   = 10;
  localparam int MS_DIV   = CLK_FREQ / 1000;

  logic sys_clk = 1'b0;
  logic sys_rst_n;

  int checks   = 0;
  int failures = 0;
  int hi_cnt   = 0;
  int run_len  = 0;
  int ovf_cnt  = 0;
  logic [7:0] run_tone = 8'd0;
  int runs[$];

  note_sequencer_if #(.DEPTH(DEPTH)) bus ();

  note_sequencer #(.CLK_FREQ(CLK_FREQ), .DEPTH(DEPTH), .GAP_MS(GAP_MS)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Records every contiguous stretch of sound as (tone << 16) | length_in_cycles.
  always @(negedge sys_clk) begin
    if (bus.tone_en === 1'b1) begin
      hi_cnt++;
      run_len++;
      run_tone = bus.tone;
    end else if (run_len != 0) begin
      runs.push_back((int'(run_tone) << 16) | run_len);
      run_len = 0;
    end
    if (bus.overflow === 1'b1) ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge sys_clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge sys_clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] nt, input logic [7:0] du);
    send_byte(nt);
    send_byte(du);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < bound) begin
      @(negedge sys_clk);
      n++;
    end
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int base, h, n, exp_ovf, np;
    logic [7:0] nt, du;
    logic [15:0] q[$];
    int exp_q[$];

    sys_rst_n    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    bus.play_en  = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_tone",     32'(bus.tone),       0);
    check("rst_tone_en",  32'(bus.tone_en),    0);
    check("rst_busy",     32'(bus.busy),       0);
    check("rst_count",    32'(bus.fifo_count), 0);
    check("rst_overflow", 32'(bus.overflow),   0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Single note: 2 x 10 ms sounding, then a 10 ms gap.
    bus.play_en = 1'b1;
    send_pair(8'h05, 8'h02);
    n = 0;
    while (bus.tone_en !== 1'b1 && n < 50) begin @(negedge sys_clk); n++; end
    check("p1_start", 32'(bus.tone_en), 1);
    check("p1_tone",  32'(bus.tone), 5);
    h = 0; n = 0;
    while (bus.tone_en === 1'b1 && n < 1000) begin h++; @(negedge sys_clk); n++; end
    check("p1_len", h, 2 * 10 * MS_DIV);
    h = 0; n = 0;
    while (bus.tone_en === 1'b0 && bus.busy === 1'b1 && n < 1000) begin h++; @(negedge sys_clk); n++; end
    check("p1_gap",  h, GAP_MS * MS_DIV);
    check("p1_busy", 32'(bus.busy), 0);
    check("p1_hold", 32'(bus.tone), 5);

    // Zero duration: tone loaded, never sounded, no gap.
    base = hi_cnt;
    send_pair(8'h09, 8'h00);
    repeat (4) @(negedge sys_clk);
    check("z_tone", 32'(bus.tone), 9);
    check("z_busy", 32'(bus.busy), 0);
    check("z_hi",   hi_cnt - base, 0);

    // Pause after 60 sounding cycles, resume for the remainder.
    send_pair(8'h03, 8'h02);
    h = 0; n = 0;
    while (h < 60 && n < 200) begin
      @(negedge sys_clk); n++;
      if (bus.tone_en === 1'b1) h++;
    end
    check("pause_pre", h, 60);
    bus.play_en = 1'b0;
    h = 0;
    repeat (500) begin
      @(negedge sys_clk);
      if (bus.tone_en === 1'b1) h++;
    end
    check("pause_hold", h, 0);
    check("pause_busy", 32'(bus.busy), 1);
    bus.play_en = 1'b1;
    h = 0; n = 0;
    while (bus.busy === 1'b1 && n < 2000) begin
      @(negedge sys_clk); n++;
      if (bus.tone_en === 1'b1) h++;
    end
    check("pause_post", h, 2 * 10 * MS_DIV - 60);
    check("pause_idle", 32'(bus.busy), 0);

    // Lone byte then 300 ms of silence: the stale note must be discarded.
    runs.delete();
    send_byte(8'h04);
    repeat (300 * MS_DIV) @(negedge sys_clk);
    check("resync_busy", 32'(bus.busy), 0);
    send_pair(8'h07, 8'h01);
    wait_idle("resync", 1000);
    repeat (2) @(negedge sys_clk);
    check("resync_runs", runs.size(), 1);
    check("resync_run0", (runs.size() > 0) ? runs[0] : -1, (7 << 16) | (10 * MS_DIV));

    // Fill beyond capacity while paused, then drain in order.
    bus.play_en = 1'b0;
    runs.delete();
    base = ovf_cnt;
    for (int i = 1; i <= 16; i++) send_pair(8'(i), 8'd1);
    repeat (2) @(negedge sys_clk);
    check("fill_count", 32'(bus.fifo_count), 16);
    check("fill_ovf0",  ovf_cnt - base, 0);
    send_pair(8'd17, 8'd1);
    repeat (2) @(negedge sys_clk);
    check("fill_ovf",     ovf_cnt - base, 1);
    check("fill_count17", 32'(bus.fifo_count), 16);
    bus.play_en = 1'b1;
    wait_idle("drain", 10000);
    repeat (2) @(negedge sys_clk);
    check("drain_runs", runs.size(), 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("drain_%0d", i), (i < runs.size()) ? runs[i] : -1, ((i + 1) << 16) | (10 * MS_DIV));

    // Random pair streams; the last round plays live while bytes arrive.
    for (int r = 0; r < 4; r++) begin
      bus.play_en = (r == 3);
      q.delete();
      exp_q.delete();
      runs.delete();
      exp_ovf = 0;
      base = ovf_cnt;
      np = (r == 3) ? int'($urandom_range(12, 4)) : int'($urandom_range(22, 4));
      for (int k = 0; k < np; k++) begin
        nt = ($urandom_range(7, 0) == 0) ? 8'd0 : 8'($urandom_range(255, 1));
        du = 8'($urandom_range(3, 0));
        send_pair(nt, du);
        repeat ($urandom_range(3, 0)) @(negedge sys_clk);
        if (r == 3 || q.size() < DEPTH) q.push_back({nt, du});
        else exp_ovf++;
      end
      repeat (2) @(negedge sys_clk);
      if (r != 3) check($sformatf("rnd%0d_count", r), 32'(bus.fifo_count), q.size());
      check($sformatf("rnd%0d_ovf", r), ovf_cnt - base, exp_ovf);
      bus.play_en = 1'b1;
      wait_idle($sformatf("rnd%0d", r), 20000);
      repeat (2) @(negedge sys_clk);
      foreach (q[j])
        if (q[j][15:8] != 8'd0 && q[j][7:0] != 8'd0)
          exp_q.push_back((int'(q[j][15:8]) << 16) | (int'(q[j][7:0]) * 10 * MS_DIV));
      check($sformatf("rnd%0d_runs", r), runs.size(), exp_q.size());
      foreach (exp_q[j])
        check($sformatf("rnd%0d_run%0d", r, j), (j < runs.size()) ? runs[j] : -1, exp_q[j]);
      if (q.size() > 0) check($sformatf("rnd%0d_tone", r), 32'(bus.tone), 32'(q[q.size() - 1][15:8]));
    end

    // Reset while a note plays with three pairs queued.
    bus.play_en = 1'b1;
    for (int i = 0; i < 4; i++) send_pair(8'(8'h11 + i), 8'd2);
    n = 0;
    while (bus.tone_en !== 1'b1 && n < 100) begin @(negedge sys_clk); n++; end
    check("rr_playing", 32'(bus.tone_en), 1);
    check("rr_count",   32'(bus.fifo_count), 3);
    sys_rst_n = 1'b0;
    #1;
    check("rr_tone",     32'(bus.tone),       0);
    check("rr_tone_en",  32'(bus.tone_en),    0);
    check("rr_busy",     32'(bus.busy),       0);
    check("rr_fcount",   32'(bus.fifo_count), 0);
    check("rr_overflow", 32'(bus.overflow),   0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    runs.delete();
    base = hi_cnt;
    repeat (600) @(negedge sys_clk);
    check("rr_silent",     hi_cnt - base, 0);
    check("rr_idle",       32'(bus.busy), 0);
    check("rr_empty",      32'(bus.fifo_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
